// File: rtl/mem_writeback_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mem_writeback_stage_pkg                                 |
// | Brief  : Shared types and constants for the MEM / MEM-WB stage.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package mem_writeback_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Primary opcodes (instruction bits [31:26]) of the supported subset
  typedef enum logic [5:0] {
    OP_R    = 6'd0,
    OP_BEQ  = 6'd4,
    OP_BNE  = 6'd5,
    OP_ADDI = 6'd8,
    OP_LW   = 6'd35,
    OP_SW   = 6'd43
  } opcode_e;

  // Bundle registered into the MEM/WB pipeline register
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] instr;
  } mw_bundle_t;

endpackage
`default_nettype wire

// File: rtl/mem_writeback_stage_data_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mem_writeback_stage_data_ram                            |
// | Brief  : Word-addressed data memory, async read, sync write,     |
// |          asynchronous clear of every word.                       |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module mem_writeback_stage_data_ram
  import mem_writeback_stage_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array: cleared on reset, written on the clock edge when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read port is combinational so a load sees the pre-edge contents
  assign rdata = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/mem_writeback_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mem_writeback_stage                                     |
// | Brief  : MEM stage (lw/sw, branch resolve) plus MEM/WB register  |
// |          and saturating debug load/store counters.               |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module mem_writeback_stage
  import mem_writeback_stage_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EM_MemtoReg,
  input  logic              EM_RegWrite,
  input  logic              EM_MemRead,
  input  logic              EM_MemWrite,
  input  logic              EM_Branch,
  input  logic [DATA_W-1:0] EM_Result,
  input  logic              EM_ZERO,
  input  logic [REG_W-1:0]  EM_Rd,
  input  logic [DATA_W-1:0] EM_PC2_ADD_out,
  input  logic [DATA_W-1:0] EM_Readdata2,
  input  logic [DATA_W-1:0] EM_Instruction,
  output logic              MW_RegWrite,
  output logic              MW_MemtoReg,
  output logic [DATA_W-1:0] MW_MemData,
  output logic [DATA_W-1:0] MW_Result,
  output logic [REG_W-1:0]  MW_RD,
  output logic [DATA_W-1:0] MW_Instruction,
  output logic              PCSrc,
  output logic [DATA_W-1:0] Branch_target,
  output logic              Mem_Err,
  output logic [CNT_W-1:0]  Load_cnt,
  output logic [CNT_W-1:0]  Store_cnt
);

  logic [ADDR_W-1:0] w_idx;
  logic              w_bad_addr;
  logic              w_acc_err;
  logic              w_load_ok;
  logic              w_store_ok;
  logic [DATA_W-1:0] w_rdata;

  mw_bundle_t        mw_d, mw_q;
  logic              mem_err_d, mem_err_q;
  logic [CNT_W-1:0]  load_cnt_d, load_cnt_q;
  logic [CNT_W-1:0]  store_cnt_d, store_cnt_q;

  // Byte address -> word index; anything misaligned or beyond the array is rejected
  assign w_idx      = EM_Result[ADDR_W+1:2];
  assign w_bad_addr = (EM_Result[1:0] != 2'b00) || (EM_Result[DATA_W-1:ADDR_W+2] != '0);
  assign w_acc_err  = (EM_MemRead | EM_MemWrite) & w_bad_addr;
  assign w_load_ok  = EM_MemRead  & ~w_bad_addr;
  assign w_store_ok = EM_MemWrite & ~w_bad_addr;

  mem_writeback_stage_data_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_store_ok),
    .addr  (w_idx),
    .wdata (EM_Readdata2),
    .rdata (w_rdata)
  );

  // Branch resolution goes straight back to fetch; held low during reset
  assign PCSrc         = EM_Branch & EM_ZERO & ~rst;
  assign Branch_target = EM_PC2_ADD_out;

  // Next MEM/WB bundle, error pulse and saturating counters
  always_comb begin
    mw_d            = '0;
    mw_d.reg_write  = EM_RegWrite & ~w_acc_err;
    mw_d.mem_to_reg = EM_MemtoReg;
    mw_d.mem_data   = w_load_ok ? w_rdata : '0;
    mw_d.result     = EM_Result;
    mw_d.rd         = EM_Rd;
    mw_d.instr      = EM_Instruction;
    mem_err_d       = w_acc_err;
    load_cnt_d      = (w_load_ok  && (load_cnt_q  != '1)) ? load_cnt_q  + CNT_W'(1) : load_cnt_q;
    store_cnt_d     = (w_store_ok && (store_cnt_q != '1)) ? store_cnt_q + CNT_W'(1) : store_cnt_q;
  end

  // Pipeline register and counter state, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_q        <= '0;
      mem_err_q   <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      mw_q        <= mw_d;
      mem_err_q   <= mem_err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign MW_RegWrite    = mw_q.reg_write;
  assign MW_MemtoReg    = mw_q.mem_to_reg;
  assign MW_MemData     = mw_q.mem_data;
  assign MW_Result      = mw_q.result;
  assign MW_RD          = mw_q.rd;
  assign MW_Instruction = mw_q.instr;
  assign Mem_Err        = mem_err_q;
  assign Load_cnt       = load_cnt_q;
  assign Store_cnt      = store_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_writeback_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_mem_writeback_stage                                  |
// | Brief  : Self-checking bench for mem_writeback_stage with a      |
// |          behavioural memory/counter model.                       |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_mem_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        em_memtoreg = 0, em_regwrite = 0, em_memread = 0, em_memwrite = 0;
  logic        em_branch = 0, em_zero = 0;
  logic [31:0] em_result = 0, em_pc2 = 0, em_rd2 = 0, em_instr = 0;
  logic [4:0]  em_rd = 0;

  logic        mw_regwrite, mw_memtoreg, pcsrc, mem_err;
  logic [31:0] mw_memdata, mw_result, mw_instr, br_target;
  logic [4:0]  mw_rd;
  logic [15:0] load_cnt, store_cnt;

  logic        s_regwrite, s_memtoreg, s_pcsrc, s_mem_err;
  logic [31:0] s_memdata, s_result, s_instr, s_br_target;
  logic [4:0]  s_rd;
  logic [1:0]  s_load_cnt, s_store_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [32];
  int          ref_load, ref_store, ref_load2, ref_store2;
  logic        e_regwrite, e_memtoreg, e_err;
  logic [31:0] e_memdata, e_result, e_instr;
  logic [4:0]  e_rd;

  always #5 clk = ~clk;

  mem_writeback_stage dut (
    .clk(clk), .rst(rst),
    .EM_MemtoReg(em_memtoreg), .EM_RegWrite(em_regwrite), .EM_MemRead(em_memread),
    .EM_MemWrite(em_memwrite), .EM_Branch(em_branch), .EM_Result(em_result),
    .EM_ZERO(em_zero), .EM_Rd(em_rd), .EM_PC2_ADD_out(em_pc2),
    .EM_Readdata2(em_rd2), .EM_Instruction(em_instr),
    .MW_RegWrite(mw_regwrite), .MW_MemtoReg(mw_memtoreg), .MW_MemData(mw_memdata),
    .MW_Result(mw_result), .MW_RD(mw_rd), .MW_Instruction(mw_instr),
    .PCSrc(pcsrc), .Branch_target(br_target), .Mem_Err(mem_err),
    .Load_cnt(load_cnt), .Store_cnt(store_cnt)
  );

  mem_writeback_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .EM_MemtoReg(em_memtoreg), .EM_RegWrite(em_regwrite), .EM_MemRead(em_memread),
    .EM_MemWrite(em_memwrite), .EM_Branch(em_branch), .EM_Result(em_result),
    .EM_ZERO(em_zero), .EM_Rd(em_rd), .EM_PC2_ADD_out(em_pc2),
    .EM_Readdata2(em_rd2), .EM_Instruction(em_instr),
    .MW_RegWrite(s_regwrite), .MW_MemtoReg(s_memtoreg), .MW_MemData(s_memdata),
    .MW_Result(s_result), .MW_RD(s_rd), .MW_Instruction(s_instr),
    .PCSrc(s_pcsrc), .Branch_target(s_br_target), .Mem_Err(s_mem_err),
    .Load_cnt(s_load_cnt), .Store_cnt(s_store_cnt)
  );

  // Byte address is unusable unless word aligned and inside the 32-word array
  function automatic bit ref_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32 * 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    ref_load = 0; ref_store = 0; ref_load2 = 0; ref_store2 = 0;
  endtask

  // Predict what the MEM/WB register will hold after the coming edge
  task automatic model_edge();
    bit          bad;
    logic [31:0] old;
    int          idx;
    bad = ref_bad(em_result);
    idx = int'(em_result / 4);
    old = bad ? 32'h0 : ref_mem[idx];
    e_err      = (em_memread || em_memwrite) && bad;
    e_memdata  = (em_memread && !bad) ? old : 32'h0;
    e_regwrite = em_regwrite && !e_err;
    e_memtoreg = em_memtoreg;
    e_result   = em_result;
    e_rd       = em_rd;
    e_instr    = em_instr;
    if (em_memwrite && !bad) begin
      ref_mem[idx] = em_rd2;
      if (ref_store  < 65535) ref_store++;
      if (ref_store2 < 3)     ref_store2++;
    end
    if (em_memread && !bad) begin
      if (ref_load  < 65535) ref_load++;
      if (ref_load2 < 3)     ref_load2++;
    end
  endtask

  task automatic clock_in();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bubble();
    em_memtoreg = 0; em_regwrite = 0; em_memread = 0; em_memwrite = 0;
    em_branch = 0; em_zero = 0; em_result = 0; em_pc2 = 0; em_rd2 = 0;
    em_instr = 0; em_rd = 0;
  endtask

  task automatic test_reset();
    set_bubble();
    em_branch = 1; em_zero = 1; em_result = 32'h10; em_memwrite = 1; em_rd2 = 32'h1234;
    rst = 1;
    #1;
    checks++;
    if ({mw_regwrite, mw_memtoreg, mw_memdata, mw_result, mw_rd, mw_instr, mem_err} !== '0) begin
      errors++;
      $display("FAIL reset_mw: got %h required 0",
               {mw_regwrite, mw_memtoreg, mw_memdata, mw_result, mw_rd, mw_instr, mem_err});
    end
    checks++;
    if ({load_cnt, store_cnt, s_load_cnt, s_store_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %h required 0", {load_cnt, store_cnt, s_load_cnt, s_store_cnt});
    end
    checks++;
    if (pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL reset_pcsrc: got %b required 0", pcsrc);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    set_bubble();
    #1;
  endtask

  task automatic test_store_load();
    set_bubble();
    em_memwrite = 1; em_result = 32'h10; em_rd2 = 32'hDEADBEEF;
    em_instr = {6'd43, 26'h0};
    clock_in();
    checks++;
    if (store_cnt !== 16'd1 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_cnt: got cnt=%0d err=%b required cnt=1 err=0", store_cnt, mem_err);
    end
    set_bubble();
    em_memread = 1; em_memtoreg = 1; em_regwrite = 1; em_result = 32'h10; em_rd = 5'd3;
    em_instr = {6'd35, 26'h0};
    clock_in();
    checks++;
    if (mw_memdata !== 32'hDEADBEEF || mw_regwrite !== 1'b1 || mw_memtoreg !== 1'b1) begin
      errors++;
      $display("FAIL lw_data: got data=%h rw=%b m2r=%b required data=deadbeef rw=1 m2r=1",
               mw_memdata, mw_regwrite, mw_memtoreg);
    end
    checks++;
    if (load_cnt !== 16'd1 || store_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lw_cnt: got load=%0d store=%0d required 1 1", load_cnt, store_cnt);
    end
    set_bubble();
    clock_in();
    checks++;
    if (mw_memdata !== 32'h0) begin
      errors++;
      $display("FAIL no_read_data: got %h required 0", mw_memdata);
    end
  endtask

  task automatic test_branch();
    set_bubble();
    em_branch = 1; em_zero = 1; em_pc2 = 32'h40; em_instr = {6'd4, 26'h0};
    #1;
    checks++;
    if (pcsrc !== 1'b1 || br_target !== 32'h40) begin
      errors++;
      $display("FAIL beq_taken: got pcsrc=%b tgt=%h required 1 40", pcsrc, br_target);
    end
    em_zero = 0;
    #1;
    checks++;
    if (pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL beq_not_taken: got pcsrc=%b required 0", pcsrc);
    end
    em_branch = 0; em_zero = 1;
    #1;
    checks++;
    if (pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL no_branch: got pcsrc=%b required 0", pcsrc);
    end
    clock_in();
  endtask

  task automatic test_bad_addr();
    logic [31:0] bad_addrs [3];
    bad_addrs[0] = 32'h12; bad_addrs[1] = 32'h80; bad_addrs[2] = 32'h0001_0010;
    for (int i = 0; i < 3; i++) begin
      set_bubble();
      em_memread = 1; em_regwrite = 1; em_memtoreg = 1; em_result = bad_addrs[i];
      clock_in();
      checks++;
      if (mem_err !== 1'b1 || mw_regwrite !== 1'b0 || mw_memdata !== 32'h0) begin
        errors++;
        $display("FAIL bad_lw[%0d]: got err=%b rw=%b data=%h required 1 0 0",
                 i, mem_err, mw_regwrite, mw_memdata);
      end
      set_bubble();
      clock_in();
      checks++;
      if (mem_err !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse[%0d]: got %b required 0", i, mem_err);
      end
    end
    // Bad stores that would alias idx 4 (misaligned) and idx 1 (out of range)
    set_bubble();
    em_memwrite = 1; em_result = 32'h12; em_rd2 = 32'h12345678;
    clock_in();
    em_result = 32'h84;
    clock_in();
    checks++;
    if (mem_err !== 1'b1 || store_cnt !== 16'(ref_store)) begin
      errors++;
      $display("FAIL bad_sw: got err=%b cnt=%0d required 1 %0d", mem_err, store_cnt, ref_store);
    end
    set_bubble();
    em_memread = 1; em_result = 32'h10;
    clock_in();
    checks++;
    if (mw_memdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bad_sw_alias4: got %h required deadbeef", mw_memdata);
    end
    em_result = 32'h4;
    clock_in();
    checks++;
    if (mw_memdata !== 32'h0) begin
      errors++;
      $display("FAIL bad_sw_alias1: got %h required 0", mw_memdata);
    end
  endtask

  task automatic test_alu();
    set_bubble();
    em_regwrite = 1; em_result = 32'd7; em_rd = 5'd9; em_instr = 32'h0123_4820;
    clock_in();
    checks++;
    if (mw_result !== 32'd7 || mw_rd !== 5'd9 || mw_regwrite !== 1'b1 || mw_memtoreg !== 1'b0
        || mw_instr !== 32'h0123_4820 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL alu_pass: got res=%h rd=%0d rw=%b m2r=%b ins=%h err=%b required 7 9 1 0 01234820 0",
               mw_result, mw_rd, mw_regwrite, mw_memtoreg, mw_instr, mem_err);
    end
  endtask

  task automatic test_counter_sat();
    set_bubble();
    em_memwrite = 1;
    for (int i = 0; i < 4; i++) begin
      em_result = 32'(i * 4 + 64);
      em_rd2 = $urandom;
      clock_in();
    end
    checks++;
    if (s_store_cnt !== 2'd3) begin
      errors++;
      $display("FAIL store_sat: got %0d required 3", s_store_cnt);
    end
    checks++;
    if (store_cnt !== 16'(ref_store)) begin
      errors++;
      $display("FAIL store_cnt_wide: got %0d required %0d", store_cnt, ref_store);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      set_bubble();
      r = int'($urandom_range(0, 7));
      em_memread  = (r <= 2) || (r == 6);
      em_memwrite = (r >= 3) && (r <= 6);
      em_regwrite = $urandom_range(0, 1);
      em_memtoreg = em_memread;
      r = int'($urandom_range(0, 9));
      if (r < 7)      em_result = 32'($urandom_range(0, 31) * 4);
      else if (r < 9) em_result = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else            em_result = 32'($urandom_range(32, 100000) * 4);
      em_rd2    = $urandom;
      em_rd     = 5'($urandom_range(0, 31));
      em_instr  = $urandom;
      em_pc2    = $urandom;
      em_branch = $urandom_range(0, 1);
      em_zero   = $urandom_range(0, 1);
      #1;
      checks++;
      if (pcsrc !== (em_branch & em_zero) || br_target !== em_pc2) begin
        errors++;
        $display("FAIL rnd_branch[%0d]: got %b %h required %b %h",
                 n, pcsrc, br_target, em_branch & em_zero, em_pc2);
      end
      clock_in();
      checks++;
      if ({mw_regwrite, mw_memtoreg, mw_memdata, mw_result, mw_rd, mw_instr, mem_err} !==
          {e_regwrite, e_memtoreg, e_memdata, e_result, e_rd, e_instr, e_err}) begin
        errors++;
        $display("FAIL rnd_mw[%0d]: got rw=%b m2r=%b d=%h res=%h rd=%0d err=%b required rw=%b m2r=%b d=%h res=%h rd=%0d err=%b",
                 n, mw_regwrite, mw_memtoreg, mw_memdata, mw_result, mw_rd, mem_err,
                 e_regwrite, e_memtoreg, e_memdata, e_result, e_rd, e_err);
      end
      checks++;
      if ({s_regwrite, s_memtoreg, s_memdata, s_result, s_rd, s_instr, s_mem_err, s_pcsrc, s_br_target} !==
          {e_regwrite, e_memtoreg, e_memdata, e_result, e_rd, e_instr, e_err, em_branch & em_zero, em_pc2}) begin
        errors++;
        $display("FAIL rnd_small_mw[%0d]: got d=%h err=%b required d=%h err=%b",
                 n, s_memdata, s_mem_err, e_memdata, e_err);
      end
      checks++;
      if (load_cnt !== 16'(ref_load) || store_cnt !== 16'(ref_store)
          || s_load_cnt !== 2'(ref_load2) || s_store_cnt !== 2'(ref_store2)) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d %0d %0d %0d required %0d %0d %0d %0d", n,
                 load_cnt, store_cnt, s_load_cnt, s_store_cnt,
                 ref_load, ref_store, ref_load2, ref_store2);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    set_bubble();
    em_memwrite = 1; em_result = 32'h20; em_rd2 = 32'hCAFEF00D; em_regwrite = 1; em_rd = 5'd4;
    #2;
    rst = 1;
    #1;
    checks++;
    if ({mw_regwrite, mw_memtoreg, mw_memdata, mw_result, mw_rd, mw_instr, mem_err,
         load_cnt, store_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: got rw=%b res=%h rd=%0d ld=%0d st=%0d required all 0",
               mw_regwrite, mw_result, mw_rd, load_cnt, store_cnt);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    set_bubble();
    em_memread = 1; em_result = 32'h20;
    clock_in();
    checks++;
    if (mw_memdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_lost_write: got %h required 0", mw_memdata);
    end
    em_result = 32'h10;
    clock_in();
    checks++;
    if (mw_memdata !== 32'h0 || load_cnt !== 16'd2) begin
      errors++;
      $display("FAIL mid_reset_mem_clear: got %h ld=%0d required 0 2", mw_memdata, load_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_store_load();
    test_branch();
    test_bad_addr();
    test_alu();
    test_counter_sat();
    test_random();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
